psum_result_collector: RTL and testbench
========================================

Name: psum_result_collector

Overview:
- Opposite end of the activation path. The activation feeder drives skewed activation rows into the systolic array; this block receives the skewed partial-sum columns leaving the array bottom.
- It de-skews the columns and stores one SIZE x SIZE result tile in a local result memory.
- It then streams the tile out row-major over a valid/ready read port to the downstream writeback/quantization stage.

Parameters:
- SIZE, 8, systolic array dimension (lanes per beat, rows per tile).
- PSUM_WIDTH, 18, width of one signed partial-sum lane.
- MEM_SIZE, SIZE*SIZE, result memory entries.
- ADDR_WIDTH, $clog2(MEM_SIZE), result memory address width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- Psum_in  input  SIZE*PSUM_WIDTH  array outputs; lane j = Psum_in[j*PSUM_WIDTH +: PSUM_WIDTH], column j.
- Psum_in_valid  input  1  lane 0 carries a valid row this cycle; lane j is valid j cycles later.
- rd_ready  input  1  consumer accepts rd_data this cycle.
- rd_valid  output  1  rd_data/rd_addr valid.
- rd_data  output  PSUM_WIDTH  signed result word.
- rd_addr  output  ADDR_WIDTH  row*SIZE+col of rd_data.
- collect_done  output  1  one-cycle pulse when the full tile is stored.
- read_done  output  1  one-cycle pulse when the last word is accepted.
- overrun  output  1  sticky; set when Psum_in_valid is seen outside IDLE/COLLECT.

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk.
- Reset clears: state=IDLE, rd_valid=0, rd_addr=0, collect_done=0, read_done=0, overrun=0, valid delay line, lane row counters. Result memory contents are not reset.
- rd_data is combinational from memory[rd_addr] and is meaningful only when rd_valid=1.
- FSM states: IDLE, COLLECT, DRAIN.
  - IDLE -> COLLECT on Psum_in_valid=1; that beat is captured.
  - COLLECT -> DRAIN when lane SIZE-1 writes its row SIZE-1.
  - DRAIN -> IDLE when the word at address MEM_SIZE-1 is accepted.
- De-skew:
  - vdly is a SIZE-bit shift register; vdly[0]=Psum_in_valid (combinational) and vdly[j] = Psum_in_valid delayed j cycles.
  - Lane j writes when vdly[j]=1 (IDLE entry beat or COLLECT), to mem[row_j*SIZE+j], then row_j increments.
  - Per-lane row counters mean gaps in Psum_in_valid are tolerated. Rows need not be contiguous.
- Timing for contiguous input: first valid at cycle t0, SIZE beats. Last write (lane SIZE-1, row SIZE-1) occurs at t0+2*SIZE-2. collect_done pulses and state becomes DRAIN at t0+2*SIZE-1.
- More than SIZE valid beats in one tile: beats SIZE+ are ignored (row counter saturated at SIZE) and overrun is set.
- DRAIN:
  - rd_valid=1, starting at rd_addr=0.
  - On rd_valid&&rd_ready, rd_addr increments.
  - rd_ready=0 holds rd_addr and rd_data stable (no drop, no duplicate).
  - At acceptance of address MEM_SIZE-1: read_done pulses the following cycle, rd_valid=0, rd_addr wraps to 0, state=IDLE.
  - Psum_in_valid during DRAIN is ignored, no memory write, overrun=1 (sticky until rst).
- Simultaneous events: read_done and a new Psum_in_valid in the same IDLE-entry cycle are legal. The new tile starts collecting, and overwriting is safe because the drain is complete.
- Reset mid-COLLECT or mid-DRAIN: immediately returns to IDLE with all outputs cleared. A partial tile is discarded; the memory may hold stale data, but it is never read without a new full collection.
- Widths: data stored verbatim, no truncation, saturation or activation function. Address arithmetic is modulo MEM_SIZE.

Test Plan:
- Contiguous tile, SIZE=8: drive Psum_in_valid for 8 cycles with lane j of beat r = 100*r+j, array-skewed. Expect collect_done at t0+15, then 64 reads with rd_data(addr)=100*(addr/8)+addr%8 and read_done after addr 63.
- Backpressure: during DRAIN toggle rd_ready 1,0,0,1 pseudo-randomly. Expect rd_addr/rd_data held while rd_ready=0, exactly 64 accepted words in order, no gaps or duplicates.
- Gapped input: valid beats at t0, t0+3, t0+4, ... (8 beats total with idle gaps), lanes correctly skewed. Expect identical memory image to the contiguous case and collect_done one cycle after the last lane-7 write.
- Overrun: assert Psum_in_valid at DRAIN address 10. Expect overrun=1 held, the read stream unchanged (addresses 10..63 return the original tile).
- Reset mid-DRAIN at rd_addr=30: expect rd_valid=0, rd_addr=0, state IDLE next edge. A subsequent full tile collects and drains with new values.
- Back-to-back tiles: start tile 2 (values 1000+addr) in the cycle after read_done. Expect tile 2 drained intact, collect_done/read_done each pulsing exactly once per tile.

Source files
------------

// File: rtl/psum_result_collector.sv
// ---------------------------------------------------------------------------
// PsumResultCollector
//
// Receives the skewed partial-sum columns leaving the bottom of the systolic
// array, de-skews them into one SIZE x SIZE result tile held in a local
// result memory, then streams that tile out row-major over a valid/ready
// read port towards the writeback/quantization stage.
//
// Ports
//   clk           clock
//   rst           asynchronous, active-high reset
//   Psum_in       SIZE lanes of signed partial sums, lane j = column j
//   Psum_in_valid lane 0 carries a valid row; lane j is valid j cycles later
//   rd_ready      consumer accepts rd_data this cycle
//   rd_valid      rd_data / rd_addr are valid (high for the whole drain)
//   rd_data       result word at rd_addr (combinational memory read)
//   rd_addr       row*SIZE+col of rd_data
//   collect_done  one-cycle pulse once the full tile is stored
//   read_done     one-cycle pulse after the last word has been accepted
//   overrun       sticky flag: input seen while it could not be accepted
// ---------------------------------------------------------------------------
module psum_result_collector #(
    parameter int SIZE       = 8,
    parameter int PSUM_WIDTH = 18,
    parameter int MEM_SIZE   = SIZE * SIZE,
    parameter int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SIZE*PSUM_WIDTH-1:0]   Psum_in,
    input  logic                         Psum_in_valid,
    input  logic                         rd_ready,
    output logic                         rd_valid,
    output logic [PSUM_WIDTH-1:0]        rd_data,
    output logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic                         collect_done,
    output logic                         read_done,
    output logic                         overrun
);

    localparam int ROW_WIDTH = $clog2(SIZE + 1);
    localparam logic [ROW_WIDTH-1:0]  ROW_FULL  = ROW_WIDTH'(SIZE);
    localparam logic [ROW_WIDTH-1:0]  ROW_LAST  = ROW_WIDTH'(SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(MEM_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } collectorState_t;

    collectorState_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] rdAddr_q, rdAddr_d;
    logic                  collectDone_q, collectDone_d;
    logic                  readDone_q, readDone_d;
    logic                  overrun_q, overrun_d;

    // Delay line of accepted lane-0 beats; bit j-1 holds the beat from j cycles ago
    logic [SIZE-2:0]       vdlyShift_q;
    logic [SIZE-1:0]       vdly;

    // Per-lane row counters; SIZE means the lane has already stored its full column
    logic [ROW_WIDTH-1:0]  row_q [SIZE];
    logic [ROW_WIDTH-1:0]  row_d [SIZE];

    logic [PSUM_WIDTH-1:0] mem [MEM_SIZE];

    logic                  acceptState;
    logic                  lane0Accept;
    logic [SIZE-1:0]       laneWe;
    logic [ADDR_WIDTH-1:0] laneAddr [SIZE];
    logic                  finalWrite;
    logic                  rdAccept;

    // Input beats are only taken while idle or collecting. A beat is only
    // entered into the delay line when lane 0 still has room, so surplus beats
    // never reach the other lanes and the delay line is empty after a tile.
    always_comb begin
        acceptState = (state_q == IDLE) || (state_q == COLLECT);
        lane0Accept = Psum_in_valid && acceptState && (row_q[0] < ROW_FULL);
        vdly        = {vdlyShift_q, lane0Accept};
    end

    // Lane j stores its column entry for the row its own counter points at.
    // The tile is complete when the last lane writes its last row.
    always_comb begin
        for (int j = 0; j < SIZE; j++) begin
            laneWe[j]   = vdly[j] && acceptState && (row_q[j] < ROW_FULL);
            laneAddr[j] = ADDR_WIDTH'(row_q[j]) * ADDR_WIDTH'(SIZE) + ADDR_WIDTH'(j);
        end
        finalWrite = laneWe[SIZE-1] && (row_q[SIZE-1] == ROW_LAST);
    end

    // Row counters advance per lane so gaps in the input stream are harmless;
    // all counters restart together once the tile is complete.
    always_comb begin
        for (int j = 0; j < SIZE; j++) begin
            row_d[j] = row_q[j] + ROW_WIDTH'(laneWe[j]);
            if (finalWrite) begin
                row_d[j] = '0;
            end
        end
    end

    // Next-state and output-register logic for the collect/drain controller
    always_comb begin
        state_d       = state_q;
        rdAddr_d      = rdAddr_q;
        readDone_d    = 1'b0;
        collectDone_d = finalWrite;
        overrun_d     = overrun_q;

        if (Psum_in_valid && (!acceptState || (row_q[0] >= ROW_FULL))) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (lane0Accept) begin
                    state_d = finalWrite ? DRAIN : COLLECT;
                end
            end
            COLLECT: begin
                if (finalWrite) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rdAccept) begin
                    if (rdAddr_q == ADDR_LAST) begin
                        rdAddr_d   = '0;
                        readDone_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        rdAddr_d = rdAddr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller and de-skew state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rdAddr_q      <= '0;
            collectDone_q <= 1'b0;
            readDone_q    <= 1'b0;
            overrun_q     <= 1'b0;
            vdlyShift_q   <= '0;
            for (int j = 0; j < SIZE; j++) begin
                row_q[j] <= '0;
            end
        end else begin
            state_q       <= state_d;
            rdAddr_q      <= rdAddr_d;
            collectDone_q <= collectDone_d;
            readDone_q    <= readDone_d;
            overrun_q     <= overrun_d;
            vdlyShift_q   <= vdly[SIZE-2:0];
            for (int j = 0; j < SIZE; j++) begin
                row_q[j] <= row_d[j];
            end
        end
    end

    // Result memory: several lanes write distinct addresses in the same cycle.
    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int j = 0; j < SIZE; j++) begin
            if (laneWe[j]) begin
                mem[laneAddr[j]] <= Psum_in[j*PSUM_WIDTH +: PSUM_WIDTH];
            end
        end
    end

    // Read port: valid for the whole drain, data read straight from memory
    always_comb begin
        rd_valid     = (state_q == DRAIN);
        rdAccept     = rd_valid && rd_ready;
        rd_addr      = rdAddr_q;
        rd_data      = mem[rdAddr_q];
        collect_done = collectDone_q;
        read_done    = readDone_q;
        overrun      = overrun_q;
    end

endmodule

// File: tb/tb_psum_result_collector.sv
// ---------------------------------------------------------------------------
// TbPsumResultCollector
//
// Drives array-skewed tiles into psum_result_collector and checks the drained
// stream against a tile image held in the bench. Lane j in cycle c carries
// column j of whichever row was issued on lane 0 in cycle c-j; lanes with no
// row in flight carry random junk that must be ignored.
// ---------------------------------------------------------------------------
module tb_psum_result_collector;

    localparam int SIZE = 8;
    localparam int PW   = 18;
    localparam int MEM  = SIZE * SIZE;
    localparam int AW   = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [SIZE*PW-1:0] Psum_in;
    logic              Psum_in_valid;
    logic              rd_ready;
    logic              rd_valid;
    logic [PW-1:0]     rd_data;
    logic [AW-1:0]     rd_addr;
    logic              collect_done;
    logic              read_done;
    logic              overrun;

    int                errors = 0;
    int                checks = 0;
    int                cycleNo = 0;
    int                histRow [64];
    logic [PW-1:0]     tileVals [MEM];
    int                collectPulses = 0;
    int                readPulses = 0;
    int                expCollect = 0;
    int                expRead = 0;
    bit                expOverrun = 1'b0;

    always #5 clk = ~clk;

    psum_result_collector #(
        .SIZE       (SIZE),
        .PSUM_WIDTH (PW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .Psum_in       (Psum_in),
        .Psum_in_valid (Psum_in_valid),
        .rd_ready      (rd_ready),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_addr       (rd_addr),
        .collect_done  (collect_done),
        .read_done     (read_done),
        .overrun       (overrun)
    );

    // Count completion pulses away from the active edge
    always @(negedge clk) begin
        if (collect_done === 1'b1) collectPulses++;
        if (read_done === 1'b1) readPulses++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cycleNo);
        end
    endtask

    task automatic clearHistory();
        for (int i = 0; i < 64; i++) histRow[i] = -1;
    endtask

    // Drive one cycle of inputs (row < 0 means no tile row issued on lane 0),
    // then advance past the next rising edge.
    task automatic applyStimulus(input bit v, input int row, input bit ready);
        histRow[cycleNo % 64] = v ? row : -1;
        for (int j = 0; j < SIZE; j++) begin
            int c;
            int r;
            c = cycleNo - j;
            r = (c >= 0) ? histRow[c % 64] : -1;
            Psum_in[j*PW +: PW] = (r >= 0) ? tileVals[r*SIZE + j] : PW'($urandom);
        end
        Psum_in_valid = v;
        rd_ready      = ready;
        @(posedge clk);
        #1;
        cycleNo++;
    endtask

    task automatic fillRandom();
        for (int i = 0; i < MEM; i++) tileVals[i] = PW'($urandom);
    endtask

    // Issue SIZE rows (plus an optional surplus row) and wait for collect_done
    task automatic sendTile(input bit gapped, input bit extraBeat);
        int beats;
        int gap;
        int lastBeat;
        int n;
        int nBeats;
        beats    = 0;
        gap      = 0;
        lastBeat = -1;
        n        = 0;
        nBeats   = extraBeat ? SIZE + 1 : SIZE;
        while (beats < nBeats) begin
            if (gap > 0) begin
                applyStimulus(1'b0, -1, 1'b0);
                gap--;
            end else begin
                if (beats < SIZE) lastBeat = cycleNo;
                applyStimulus(1'b1, (beats < SIZE) ? beats : -1, 1'b0);
                beats++;
                if (gapped) gap = (beats == 1) ? 2 : int'($urandom_range(0, 2));
            end
        end
        if (extraBeat) expOverrun = 1'b1;
        while (collect_done !== 1'b1 && n < 40) begin
            applyStimulus(1'b0, -1, 1'b0);
            n++;
        end
        checkOutput("collect_done", collect_done, 1);
        checkOutput("collect_cycle", cycleNo, lastBeat + SIZE);
        checkOutput("drain_valid", rd_valid, 1);
        checkOutput("drain_start_addr", rd_addr, 0);
        expCollect++;
    endtask

    // Drain the tile, optionally with backpressure, stopping early at stopAt,
    // and optionally driving input beats from drain address ovrAt onwards.
    task automatic drainTile(input bit bp, input int stopAt, input int ovrAt);
        int idx;
        int n;
        bit ready;
        bit inj;
        idx = 0;
        n   = 0;
        while (idx < MEM && n < 400 && (stopAt < 0 || idx < stopAt)) begin
            checkOutput("rd_valid", rd_valid, 1);
            checkOutput("rd_addr", rd_addr, idx);
            checkOutput("rd_data", rd_data, tileVals[idx]);
            checkOutput("read_done_low", read_done, 0);
            checkOutput("overrun", overrun, expOverrun);
            ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            inj   = (ovrAt >= 0) && (idx >= ovrAt) && (idx < ovrAt + 3);
            if (inj) expOverrun = 1'b1;
            applyStimulus(inj, -1, ready);
            if (ready) idx++;
            n++;
        end
        if (stopAt < 0) begin
            checkOutput("drain_words", idx, MEM);
            checkOutput("read_done", read_done, 1);
            checkOutput("rd_valid_after", rd_valid, 0);
            checkOutput("rd_addr_wrap", rd_addr, 0);
            checkOutput("overrun_end", overrun, expOverrun);
            expRead++;
        end else begin
            checkOutput("drain_stop_addr", rd_addr, stopAt);
        end
    endtask

    initial begin
        int cBefore;
        int rBefore;

        rst           = 1'b1;
        Psum_in       = '0;
        Psum_in_valid = 1'b0;
        rd_ready      = 1'b0;
        clearHistory();
        applyStimulus(1'b0, -1, 1'b0);
        applyStimulus(1'b0, -1, 1'b0);
        checkOutput("reset_rd_valid", rd_valid, 0);
        checkOutput("reset_rd_addr", rd_addr, 0);
        checkOutput("reset_collect_done", collect_done, 0);
        checkOutput("reset_read_done", read_done, 0);
        checkOutput("reset_overrun", overrun, 0);
        rst = 1'b0;
        applyStimulus(1'b0, -1, 1'b0);

        $display("[TB] tile A: contiguous, 100*row+col, no backpressure");
        for (int i = 0; i < MEM; i++) tileVals[i] = PW'(100 * (i / SIZE) + (i % SIZE));
        sendTile(1'b0, 1'b0);
        drainTile(1'b0, -1, -1);

        $display("[TB] tile B: contiguous random, backpressure");
        fillRandom();
        sendTile(1'b0, 1'b0);
        drainTile(1'b1, -1, -1);

        $display("[TB] tile C: gapped random, backpressure");
        fillRandom();
        sendTile(1'b1, 1'b0);
        drainTile(1'b1, -1, -1);

        $display("[TB] tile D: input during drain from address 10");
        fillRandom();
        sendTile(1'b0, 1'b0);
        drainTile(1'b1, -1, 10);

        $display("[TB] tile E: reset mid-drain at address 30");
        fillRandom();
        sendTile(1'b1, 1'b0);
        drainTile(1'b1, 30, -1);
        rst        = 1'b1;
        expOverrun = 1'b0;
        #1;
        checkOutput("async_rst_rd_valid", rd_valid, 0);
        checkOutput("async_rst_rd_addr", rd_addr, 0);
        checkOutput("async_rst_overrun", overrun, 0);
        applyStimulus(1'b0, -1, 1'b1);
        rst = 1'b0;
        clearHistory();
        applyStimulus(1'b0, -1, 1'b1);
        checkOutput("post_rst_rd_valid", rd_valid, 0);
        checkOutput("post_rst_rd_addr", rd_addr, 0);
        checkOutput("post_rst_read_done", read_done, 0);

        $display("[TB] tiles F and G: back-to-back");
        cBefore = collectPulses;
        rBefore = readPulses;
        for (int i = 0; i < MEM; i++) tileVals[i] = PW'(1000 + i);
        sendTile(1'b0, 1'b0);
        drainTile(1'b1, -1, -1);
        fillRandom();
        sendTile(1'b0, 1'b0);
        drainTile(1'b0, -1, -1);
        applyStimulus(1'b0, -1, 1'b0);
        checkOutput("b2b_collect_pulses", collectPulses - cBefore, 2);
        checkOutput("b2b_read_pulses", readPulses - rBefore, 2);
        checkOutput("read_done_one_cycle", read_done, 0);

        $display("[TB] tile H: surplus input row");
        fillRandom();
        sendTile(1'b0, 1'b1);
        drainTile(1'b1, -1, -1);

        applyStimulus(1'b0, -1, 1'b0);
        checkOutput("total_collect_pulses", collectPulses, expCollect);
        checkOutput("total_read_pulses", readPulses, expRead);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
